ng_rbus_arb: RTL and testbench

Read-bus arbiter and sequencer for the priority read-bus mux. Ten read-bus sources request the shared read bus. The block grants one source at a time and drives the mux's ten active-low source enables. When no source holds the bus, all enables are high and the mux falls back to the ALU bus. It adds a configurable turnaround gap, a hold-time limit with lockout, and round-robin or fixed-priority selection.

---
 rtl/ng_rbus_arb.sv | 131 +++++++++++++
 tb/tb_ng_rbus_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ng_rbus_arb.sv
// Read-bus arbiter: grants one of ten read-bus sources at a time and drives the
// priority mux's active-low enables, with turnaround gap, hold limit and lockout.
module ng_rbus_arb #(
    parameter int HOLD_MAX = 8,
    parameter int GAP_CYC  = 1
) (
    input  logic       CLK1,
    input  logic       RESET,
    input  logic [9:0] REQ,
    input  logic       PRIO_MODE,
    output logic [9:0] GNT,
    output logic [9:0] EN_N,
    output logic       BUSY,
    output logic [3:0] OWNER,
    output logic       TIMEOUT
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
    localparam logic [1:0] GAP_LAST  = 2'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    state_t     state, state_nxt;
    logic [9:0] gnt, gnt_nxt;
    logic [9:0] en_n;
    logic       busy;
    logic [3:0] owner, owner_nxt;
    logic [3:0] hold_cnt, hold_nxt;
    logic [1:0] gap_cnt, gap_nxt;
    logic [9:0] lock, lock_nxt;
    logic       timeout, timeout_nxt;
    logic [4:0] pick;
    logic       arb_en;

    // Returns {found, index}; round-robin starts the search just after 'last'.
    function automatic logic [4:0] arb_pick(input logic [9:0] elig,
                                            input logic [3:0] last,
                                            input logic       prio);
        logic       found;
        logic [3:0] idx;
        int         cand;
        found = 1'b0;
        idx   = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (prio) cand = k;
            else      cand = (int'(last) + 1 + k) % 10;
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = 4'(cand);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        owner_nxt   = owner;
        hold_nxt    = hold_cnt;
        gap_nxt     = gap_cnt;
        lock_nxt    = lock & REQ;
        timeout_nxt = 1'b0;
        arb_en      = 1'b0;
        pick        = arb_pick(REQ & ~lock, owner, PRIO_MODE);

        case (state)
            IDLE: arb_en = 1'b1;
            GRANT: begin
                hold_nxt = hold_cnt + 4'd1;
                if (!REQ[owner] || hold_cnt == HOLD_LAST) begin
                    gnt_nxt   = 10'd0;
                    hold_nxt  = 4'd0;
                    gap_nxt   = 2'd0;
                    state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
                    // Hold limit hit while still requesting: pulse and lock out.
                    if (REQ[owner]) begin
                        timeout_nxt     = 1'b1;
                        lock_nxt[owner] = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) arb_en = 1'b1;
                else                     gap_nxt = gap_cnt + 2'd1;
            end
            default: state_nxt = IDLE;
        endcase

        if (arb_en) begin
            state_nxt = IDLE;
            gap_nxt   = 2'd0;
            if (pick[4]) begin
                state_nxt = GRANT;
                owner_nxt = pick[3:0];
                gnt_nxt   = 10'd1 << pick[3:0];
                hold_nxt  = 4'd0;
            end
        end
    end

    always_ff @(posedge CLK1) begin
        if (RESET) begin
            state    <= IDLE;
            gnt      <= 10'd0;
            en_n     <= 10'h3FF;
            busy     <= 1'b0;
            owner    <= 4'd9;
            hold_cnt <= 4'd0;
            gap_cnt  <= 2'd0;
            lock     <= 10'd0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            en_n     <= ~gnt_nxt;
            busy     <= (state_nxt == GRANT);
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
            gap_cnt  <= gap_nxt;
            lock     <= lock_nxt;
            timeout  <= timeout_nxt;
        end
    end

    assign GNT     = gnt;
    assign EN_N    = en_n;
    assign BUSY    = busy;
    assign OWNER   = owner;
    assign TIMEOUT = timeout;

endmodule

// File: tb/tb_ng_rbus_arb.sv
// Bench for ng_rbus_arb: two configurations driven in lockstep and compared
// every cycle against a tenure-level reference model.
module tb_ng_rbus_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] req;
    logic       prio;

    logic [9:0] gnt_a, en_n_a, gnt_b, en_n_b;
    logic       busy_a, to_a, busy_b, to_b;
    logic [3:0] owner_a, owner_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    ng_rbus_arb #(.HOLD_MAX(4), .GAP_CYC(1)) dut_a (
        .CLK1(clk), .RESET(rst), .REQ(req), .PRIO_MODE(prio),
        .GNT(gnt_a), .EN_N(en_n_a), .BUSY(busy_a), .OWNER(owner_a), .TIMEOUT(to_a)
    );

    ng_rbus_arb #(.HOLD_MAX(2), .GAP_CYC(0)) dut_b (
        .CLK1(clk), .RESET(rst), .REQ(req), .PRIO_MODE(prio),
        .GNT(gnt_b), .EN_N(en_n_b), .BUSY(busy_b), .OWNER(owner_b), .TIMEOUT(to_b)
    );

    wire [51:0] obs = {gnt_a, en_n_a, busy_a, owner_a, to_a,
                       gnt_b, en_n_b, busy_b, owner_b, to_b};

    // Reference model: who holds the bus, how many cycles it has held it,
    // how many gap cycles remain, and which requesters are locked out.
    bit         m_on[2];
    bit         m_to[2];
    int         m_owner[2];
    int         m_tenure[2];
    int         m_gap[2];
    logic [9:0] m_lock[2];

    function automatic int hold_of(input int u);
        return (u == 0) ? 4 : 2;
    endfunction

    function automatic int gap_of(input int u);
        return (u == 0) ? 1 : 0;
    endfunction

    function automatic int winner(input logic [9:0] elig, input int last, input bit p);
        if (p) begin
            for (int i = 0; i < 10; i++) if (elig[i]) return i;
        end else begin
            for (int k = 1; k <= 10; k++) if (elig[(last + k) % 10]) return (last + k) % 10;
        end
        return -1;
    endfunction

    task automatic model_step(input int u);
        logic [9:0] nl;
        int         w;
        if (rst) begin
            m_on[u] = 0; m_to[u] = 0; m_owner[u] = 9;
            m_tenure[u] = 0; m_gap[u] = 0; m_lock[u] = 10'd0;
        end else begin
            nl      = m_lock[u] & req;
            m_to[u] = 0;
            if (m_on[u]) begin
                if (!req[m_owner[u]] || m_tenure[u] == hold_of(u)) begin
                    if (req[m_owner[u]]) begin
                        m_to[u] = 1;
                        nl[m_owner[u]] = 1'b1;
                    end
                    m_on[u]  = 0;
                    m_gap[u] = gap_of(u);
                end else begin
                    m_tenure[u]++;
                end
            end else if (m_gap[u] > 1) begin
                m_gap[u]--;
            end else begin
                m_gap[u] = 0;
                w = winner(req & ~m_lock[u], m_owner[u], prio);
                if (w >= 0) begin
                    m_on[u] = 1; m_owner[u] = w; m_tenure[u] = 1;
                end
            end
            m_lock[u] = nl;
        end
    endtask

    function automatic logic [25:0] expv(input int u);
        logic [9:0] g;
        g = m_on[u] ? (10'd1 << m_owner[u]) : 10'd0;
        return {g, ~g, m_on[u], 4'(m_owner[u]), m_to[u]};
    endfunction

    task automatic cyc(input logic [9:0] r, input logic p, input logic rs);
        req = r; prio = p; rst = rs;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 8; c++) begin
            cyc(10'd0, 1'b0, c < 2);
            n_total++;
            if (obs !== {expv(0), expv(1)}) $display("FAIL reset cyc=%0d dut=%h model=%h", c, obs, {expv(0), expv(1)});
            else n_pass++;
        end
        n_total++;
        if ({en_n_a, en_n_b, owner_a, owner_b} !== {10'h3FF, 10'h3FF, 4'd9, 4'd9})
            $display("FAIL reset_idle dut=%h required=%h", {en_n_a, en_n_b, owner_a, owner_b}, {10'h3FF, 10'h3FF, 4'd9, 4'd9});
        else n_pass++;
    endtask

    task automatic test_single();
        for (int c = 0; c < 8; c++) begin
            cyc((c < 3) ? 10'h008 : 10'h000, 1'b0, 1'b0);
            n_total++;
            if (obs !== {expv(0), expv(1)}) $display("FAIL single cyc=%0d dut=%h model=%h", c, obs, {expv(0), expv(1)});
            else n_pass++;
            if (c == 0) begin
                n_total++;
                if ({gnt_a, en_n_a} !== {10'h008, 10'h3F7}) $display("FAIL single_latency dut=%h required=%h", {gnt_a, en_n_a}, {10'h008, 10'h3F7});
                else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        for (int c = 0; c < 56; c++) begin
            cyc((c >= 40 && c < 42) ? 10'h000 : 10'h3FF, 1'b0, 1'b0);
            n_total++;
            if (obs !== {expv(0), expv(1)}) $display("FAIL round_robin cyc=%0d dut=%h model=%h", c, obs, {expv(0), expv(1)});
            else n_pass++;
        end
        for (int c = 0; c < 4; c++) cyc(10'h000, 1'b0, 1'b0);
    endtask

    task automatic test_fixed_prio();
        for (int c = 0; c < 16; c++) begin
            cyc((c < 2) ? 10'h0A0 : (c < 12) ? 10'h0A2 : 10'h000, 1'b1, 1'b0);
            n_total++;
            if (obs !== {expv(0), expv(1)}) $display("FAIL fixed_prio cyc=%0d dut=%h model=%h", c, obs, {expv(0), expv(1)});
            else n_pass++;
            if (c == 1) begin
                n_total++;
                if (owner_a !== 4'd5) $display("FAIL fixed_prio_owner dut=%0d required=5", owner_a);
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        for (int c = 0; c < 32; c++) begin
            cyc((c < 20 || (c >= 21 && c < 28)) ? 10'h200 : 10'h000, 1'b0, 1'b0);
            if (c < 20 && to_a) pulses++;
            n_total++;
            if (obs !== {expv(0), expv(1)}) $display("FAIL timeout cyc=%0d dut=%h model=%h", c, obs, {expv(0), expv(1)});
            else n_pass++;
        end
        n_total++;
        if (pulses !== 1) $display("FAIL timeout_pulses dut=%0d required=1", pulses);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 8; c++) begin
            cyc((c < 2) ? 10'h040 : 10'h041, 1'b0, c == 2);
            n_total++;
            if (obs !== {expv(0), expv(1)}) $display("FAIL reset_mid cyc=%0d dut=%h model=%h", c, obs, {expv(0), expv(1)});
            else n_pass++;
            if (c == 3) begin
                n_total++;
                if ({gnt_a, owner_a, to_a} !== {10'h001, 4'd0, 1'b0}) $display("FAIL reset_mid_regrant dut=%h required=%h", {gnt_a, owner_a, to_a}, {10'h001, 4'd0, 1'b0});
                else n_pass++;
            end
        end
        for (int c = 0; c < 4; c++) cyc(10'h000, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [9:0] r;
        logic       p;
        r = 10'd0;
        p = 1'b0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 10; i++) if ($urandom_range(7) == 0) r[i] = ~r[i];
            if ($urandom_range(31) == 0) p = ~p;
            cyc(r, p, $urandom_range(99) == 0);
            n_total++;
            if (obs !== {expv(0), expv(1)}) $display("FAIL random cyc=%0d dut=%h model=%h", c, obs, {expv(0), expv(1)});
            else n_pass++;
        end
    endtask

    initial begin
        req = 10'd0; prio = 1'b0; rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            m_on[u] = 0; m_to[u] = 0; m_owner[u] = 9;
            m_tenure[u] = 0; m_gap[u] = 0; m_lock[u] = 10'd0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_prio();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
